// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM states and stream framing.
package imem_loader_pkg;

    // Loader states
    typedef enum logic [2:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StData,
        StDone,
        StErr
    } state_e;

    // Header is a big-endian word count; each instruction word is four stream bytes
    localparam int unsigned HDR_BYTES      = 2;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Collects stream bytes MSB-first into an instruction word and flags each completed word
// with a one-cycle registered pulse.
module byte_assembler
    import imem_loader_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  accept,
    input  logic [7:0]            byte_data,
    output logic                  last_byte,
    output logic                  word_valid,
    output logic [WORD_WIDTH-1:0] word
);

    localparam logic [BYTE_CNT_W-1:0] LastIdx = BYTE_CNT_W'(BYTES_PER_WORD - 1);

    logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [WORD_WIDTH-1:0] shift_q, shift_d;
    logic                  word_valid_q, word_valid_d;

    // High when the next accepted byte completes a word
    assign last_byte  = (byte_cnt_q == LastIdx);
    assign word_valid = word_valid_q;
    assign word       = shift_q;

    // Shift in accepted bytes; the counter wraps naturally after the last byte of a word
    always_comb begin
        byte_cnt_d   = byte_cnt_q;
        shift_d      = shift_q;
        word_valid_d = 1'b0;
        if (clear) begin
            byte_cnt_d = '0;
        end else if (accept) begin
            shift_d      = {shift_q[WORD_WIDTH-9:0], byte_data};
            byte_cnt_d   = byte_cnt_q + BYTE_CNT_W'(1);
            word_valid_d = last_byte;
        end
    end

    // Assembler state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt_q   <= '0;
            shift_q      <= '0;
            word_valid_q <= 1'b0;
        end else begin
            byte_cnt_q   <= byte_cnt_d;
            shift_q      <= shift_d;
            word_valid_q <= word_valid_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader. Parses a length-prefixed byte stream, writes one
// word per four bytes into instruction RAM and holds the CPU in reset until the image is in.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned INSTR_WIDTH   = 32,
    parameter int unsigned DEPTH_LOG2    = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     byte_valid,
    input  logic [7:0]               byte_data,
    output logic                     byte_ready,
    output logic                     wr_en,
    output logic [ADDRESS_WIDTH-1:0] wr_addr,
    output logic [INSTR_WIDTH-1:0]   wr_data,
    output logic                     cpu_hold,
    output logic                     done,
    output logic                     error
);

    localparam int unsigned HdrBits = 8 * HDR_BYTES;
    localparam int unsigned Depth   = 1 << DEPTH_LOG2;
    localparam logic [ADDRESS_WIDTH-1:0] AddrStep = ADDRESS_WIDTH'(BYTES_PER_WORD);

    state_e state_q, state_d;

    logic [7:0]               len_hi_q, len_hi_d;
    logic [HdrBits-1:0]       cnt_q, cnt_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic                     byte_ready_q, byte_ready_d;
    logic                     cpu_hold_q, cpu_hold_d;
    logic                     done_q, done_d;
    logic                     error_q, error_d;

    logic                     xfer;
    logic                     len_lo_xfer;
    logic                     data_xfer;
    logic                     last_byte;
    logic                     word_valid;
    logic                     final_write;
    logic                     final_byte;
    logic [HdrBits-1:0]       hdr_len;
    logic [INSTR_WIDTH-1:0]   word;

    assign xfer        = byte_valid && byte_ready_q;
    assign len_lo_xfer = xfer && (state_q == StLenLo);
    assign data_xfer   = xfer && (state_q == StData);
    assign hdr_len     = {len_hi_q, byte_data};
    // cnt_q counts words not yet written, so 1 means the word in flight is the last one
    assign final_write = word_valid && (cnt_q == HdrBits'(1));
    assign final_byte  = data_xfer && last_byte && (cnt_q == HdrBits'(1));

    byte_assembler #(
        .WORD_WIDTH (INSTR_WIDTH)
    ) u_byte_assembler (
        .clk        (clk),
        .rst        (rst),
        .clear      (len_lo_xfer),
        .accept     (data_xfer),
        .byte_data  (byte_data),
        .last_byte  (last_byte),
        .word_valid (word_valid),
        .word       (word)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; start only matters when no load is in progress
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start) state_d = StLenHi;
            end
            StLenHi: begin
                if (xfer) state_d = StLenLo;
            end
            StLenLo: begin
                if (xfer) begin
                    if (hdr_len == '0) begin
                        state_d = StDone;
                    end else if (32'(hdr_len) > Depth) begin
                        state_d = StErr;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (final_write) state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs, computed from the next state so the registered copies track the state
    always_comb begin
        byte_ready_d = (state_d == StLenHi) || (state_d == StLenLo)
                    || ((state_d == StData) && !final_byte);
        cpu_hold_d   = (state_d != StDone);
        done_d       = (state_d == StDone);
        error_d      = (state_d == StErr);
    end

    // Header latch, remaining word count and write address; address stays on the last word
    always_comb begin
        len_hi_d = len_hi_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        if (xfer && (state_q == StLenHi)) begin
            len_hi_d = byte_data;
        end
        if (len_lo_xfer) begin
            cnt_d  = hdr_len;
            addr_d = '0;
        end else if (word_valid) begin
            cnt_d = cnt_q - HdrBits'(1);
            if (!final_write) addr_d = addr_q + AddrStep;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            len_hi_q     <= '0;
            cnt_q        <= '0;
            addr_q       <= '0;
            byte_ready_q <= 1'b0;
            cpu_hold_q   <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            len_hi_q     <= len_hi_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            byte_ready_q <= byte_ready_d;
            cpu_hold_q   <= cpu_hold_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign byte_ready = byte_ready_q;
    assign wr_en      = word_valid;
    assign wr_addr    = addr_q;
    assign wr_data    = word;
    assign cpu_hold   = cpu_hold_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule
